// File: rtl/traffic_phase_timer.sv
// Multi-phase countdown timer feeding the traffic-light decode and display logic.
// Optional per-phase extension request is enabled by defining TPT_EXTEND_EN.
module traffic_phase_timer #(
  parameter int pNUM_PHASES = 3,
  parameter int pPH_WIDTH   = 2,
  parameter int pCNT_WIDTH  = 5,
  parameter int pRST_PHASE  = 1,
  parameter int pRST_TIME   = 3,
  parameter int pEXT_PHASE  = 0,
  parameter int pEXT_TIME   = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              auto_adv,
  input  logic                              hold,
  input  logic                              load,
  input  logic [pPH_WIDTH-1:0]              load_phase,
  input  logic [pNUM_PHASES*pCNT_WIDTH-1:0] phase_time,
`ifdef TPT_EXTEND_EN
  input  logic                              ext_req,
`endif
  output logic [pPH_WIDTH-1:0]              phase,
  output logic [pCNT_WIDTH-1:0]             cnt_out,
  output logic                              last,
  output logic                              phase_done
);

  localparam logic [pPH_WIDTH-1:0] LAST_PH = pPH_WIDTH'(pNUM_PHASES - 1);

  logic [pCNT_WIDTH-1:0] dur [pNUM_PHASES];
  logic [pPH_WIDTH-1:0]  phase_q, phase_d, nxt_phase;
  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  valid_load;

  genvar k;
  generate
    for (k = 0; k < pNUM_PHASES; k++) begin : g_dur
      assign dur[k] = phase_time[k*pCNT_WIDTH +: pCNT_WIDTH];
    end
  endgenerate

  // Out-of-range load requests behave exactly like cycles without a load.
  assign valid_load = load && (32'(load_phase) < 32'(pNUM_PHASES));
  assign nxt_phase  = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;

`ifdef TPT_EXTEND_EN
  localparam logic [pCNT_WIDTH:0] CNT_MAX = {1'b0, {pCNT_WIDTH{1'b1}}};

  logic                  ext_used_q, ext_used_d;
  logic                  ext_fire;
  logic [pCNT_WIDTH:0]   ext_sum;
  logic [pCNT_WIDTH-1:0] ext_cnt;

  assign ext_sum  = {1'b0, cnt_q} + (pCNT_WIDTH+1)'(pEXT_TIME);
  assign ext_cnt  = (ext_sum > CNT_MAX) ? {pCNT_WIDTH{1'b1}} : ext_sum[pCNT_WIDTH-1:0];
  assign ext_fire = ext_req && !ext_used_q && (phase_q == pPH_WIDTH'(pEXT_PHASE))
                    && (cnt_q != '0);
`endif

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef TPT_EXTEND_EN
    ext_used_d = ext_used_q;
`endif
    if (valid_load) begin
      phase_d = load_phase;
      cnt_d   = dur[load_phase];
`ifdef TPT_EXTEND_EN
      ext_used_d = 1'b0;
`endif
    end else if (hold) begin
      phase_d = phase_q;
`ifdef TPT_EXTEND_EN
    // An extension replaces the decrement for the cycle it lands in.
    end else if (ext_fire) begin
      cnt_d      = ext_cnt;
      ext_used_d = 1'b1;
`endif
    end else if (en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (auto_adv) begin
        phase_d = nxt_phase;
        cnt_d   = dur[nxt_phase];
        done_d  = 1'b1;
`ifdef TPT_EXTEND_EN
        ext_used_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= pPH_WIDTH'(pRST_PHASE);
      cnt_q   <= pCNT_WIDTH'(pRST_TIME);
      done_q  <= 1'b0;
`ifdef TPT_EXTEND_EN
      ext_used_q <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef TPT_EXTEND_EN
      ext_used_q <= ext_used_d;
`endif
    end
  end

  assign phase      = phase_q;
  assign cnt_out    = cnt_q;
  assign last       = (cnt_q == '0);
  assign phase_done = done_q;

endmodule
